// File: rtl/iic_seq_pkg.sv
// Shared definitions for the IIC command sequencer: register offsets, iCall codes,
// FSM state encoding and the queued command record.
package iic_seq_pkg;

    localparam logic [7:0] IIC_REG_CALL = 8'd0;
    localparam logic [7:0] IIC_REG_ADDR = 8'd1;
    localparam logic [7:0] IIC_REG_DATA = 8'd2;

    localparam logic [1:0] CALL_IDLE = 2'b00;
    localparam logic [1:0] CALL_WR   = 2'b10;
    localparam logic [1:0] CALL_RD   = 2'b01;

    localparam int unsigned CMD_W = 17;

    typedef enum logic [2:0] {
        StIdle,
        StWAddr,
        StWData,
        StWCall,
        StWait,
        StClear,
        StDone
    } seq_state_e;

    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] data;
    } iic_cmd_t;

    function automatic logic [1:0] call_code(input logic rw);
        return rw ? CALL_RD : CALL_WR;
    endfunction

endpackage

// File: rtl/iic_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; first word is visible on rdata_o.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module iic_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/iic_cmd_sequencer.sv
// Queues IIC commands and replays each as iAddr/iData/iCall master writes, a timed hold,
// and an iCall clear. Define IIC_SEQ_STATS_EN to add wr_count/rd_count completion counters.
module iic_cmd_sequencer
    import iic_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WR_WAIT    = 14700,
    parameter int unsigned RD_WAIT    = 19950,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_rw,
    input  logic [7:0]                    cmd_addr,
    input  logic [7:0]                    cmd_data,
    output logic                          m_chipselect,
    output logic                          m_write,
    output logic [7:0]                    m_address,
    output logic [31:0]                   m_writedata,
    output logic                          busy,
    output logic                          done,
`ifdef IIC_SEQ_STATS_EN
    output logic [15:0]                   wr_count,
    output logic [15:0]                   rd_count,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [CNT_W-1:0] WrLoad = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] RdLoad = CNT_W'(RD_WAIT - 1);

    seq_state_e       state_q, state_d;
    iic_cmd_t         cmd_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    iic_cmd_t         push_cmd, head_cmd;
    logic             fifo_full, fifo_empty, pop;

    assign push_cmd  = '{rw: cmd_rw, addr: cmd_addr, data: cmd_data};
    assign cmd_ready = !fifo_full;
    assign pop       = (state_q == StIdle) && !fifo_empty;

    iic_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk_i   (CLOCK),
        .rst_ni  (RESET),
        .push_i  (cmd_valid),
        .wdata_i (push_cmd),
        .pop_i   (pop),
        .rdata_o (head_cmd),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StWAddr;
            StWAddr: state_d = StWData;
            StWData: state_d = StWCall;
            StWCall: begin
                state_d = StWait;
                cnt_d   = cmd_q.rw ? RdLoad : WrLoad;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StClear;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StClear: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs; the bus is quiet (all zero) outside the four write states.
    always_comb begin
        m_chipselect = 1'b0;
        m_write      = 1'b0;
        m_address    = 8'd0;
        m_writedata  = 32'd0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            StWAddr: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = IIC_REG_ADDR;
                m_writedata  = {24'd0, cmd_q.addr};
                busy         = 1'b1;
            end
            StWData: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = IIC_REG_DATA;
                m_writedata  = cmd_q.rw ? 32'd0 : {24'd0, cmd_q.data};
                busy         = 1'b1;
            end
            StWCall: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = IIC_REG_CALL;
                m_writedata  = {30'd0, call_code(cmd_q.rw)};
                busy         = 1'b1;
            end
            StWait:  busy = 1'b1;
            StClear: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = IIC_REG_CALL;
                m_writedata  = {30'd0, CALL_IDLE};
                busy         = 1'b1;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) begin
                cmd_q <= head_cmd;
            end
        end
    end

`ifdef IIC_SEQ_STATS_EN
    logic [15:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (done) begin
            if (!cmd_q.rw && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (cmd_q.rw && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 1'b1;
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;
`endif

endmodule
